// File: rtl/cam_pkg.sv
// Camera pattern generator shared types: pattern modes, FSM state,
// default sensor timing (1568 PCLK lines, 510-line frames).
package cam_pkg;

    typedef enum logic [1:0] {
        MODE_LEGACY = 2'd0,
        MODE_BARS   = 2'd1,
        MODE_RAMP   = 2'd2,
        MODE_FIXED  = 2'd3
    } cam_mode_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } cam_state_e;

    localparam int DEF_HEND      = 1567;
    localparam int DEF_HON       = 287;
    localparam int DEF_VEND      = 509;
    localparam int DEF_VPEND     = 2;
    localparam int DEF_VBEND     = 19;
    localparam int DEF_HWIDTH    = 11;
    localparam int DEF_VWIDTH    = 9;
    localparam int DEF_DW        = 8;
    localparam int DEF_BAR_SHIFT = 7;

endpackage

// File: rtl/cam_timing_cnt.sv
// Horizontal/vertical raster counters with frame and window flags.
// Ports: PCLK, RST_N, run (count enable); h_cnt, v_cnt, frame_first,
// frame_end, line_active (active pixel window), vsync_line.
module cam_timing_cnt
    import cam_pkg::*;
#(
    parameter int HEND   = DEF_HEND,
    parameter int HON    = DEF_HON,
    parameter int VEND   = DEF_VEND,
    parameter int VPEND  = DEF_VPEND,
    parameter int VBEND  = DEF_VBEND,
    parameter int HWIDTH = DEF_HWIDTH,
    parameter int VWIDTH = DEF_VWIDTH
) (
    input  logic              PCLK,
    input  logic              RST_N,
    input  logic              run,
    output logic [HWIDTH-1:0] h_cnt,
    output logic [VWIDTH-1:0] v_cnt,
    output logic              frame_first,
    output logic              frame_end,
    output logic              line_active,
    output logic              vsync_line
);

    logic h_end;
    logic v_end;

    assign h_end = (h_cnt == HWIDTH'(HEND));
    assign v_end = (v_cnt == VWIDTH'(VEND));

    assign frame_first = (h_cnt == '0) && (v_cnt == '0);
    assign frame_end   = h_end && v_end;
    // h never exceeds HEND, so only the lower bounds matter
    assign line_active = (h_cnt > HWIDTH'(HON)) &&
                         (v_cnt > VWIDTH'(VBEND));
    assign vsync_line  = (v_cnt <= VWIDTH'(VPEND));

    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (run) begin
            if (h_end) begin
                h_cnt <= '0;
                v_cnt <= v_end ? '0 : v_cnt + 1'b1;
            end else begin
                h_cnt <= h_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/cam_pattern_gen.sv
// Camera sensor emulator: raster timing plus selectable test pattern.
// Ports: PCLK, RST_N, EN, MODE, FIXED_VAL in; CamHsync, CamVsync,
// CamData, FrameStart, FrameCnt out (all registered).
module cam_pattern_gen
    import cam_pkg::*;
#(
    parameter int HEND      = DEF_HEND,
    parameter int HON       = DEF_HON,
    parameter int VEND      = DEF_VEND,
    parameter int VPEND     = DEF_VPEND,
    parameter int VBEND     = DEF_VBEND,
    parameter int HWIDTH    = DEF_HWIDTH,
    parameter int VWIDTH    = DEF_VWIDTH,
    parameter int DW        = DEF_DW,
    parameter int BAR_SHIFT = DEF_BAR_SHIFT
) (
    input  logic          PCLK,
    input  logic          RST_N,
    input  logic          EN,
    input  logic [1:0]    MODE,
    input  logic [DW-1:0] FIXED_VAL,
    output logic          CamHsync,
    output logic          CamVsync,
    output logic [DW-1:0] CamData,
    output logic          FrameStart,
    output logic [15:0]   FrameCnt
);

    cam_state_e        state;
    cam_mode_e         mode_q;
    logic [DW-1:0]     fixed_q;
    logic [15:0]       frame_cnt;

    logic [HWIDTH-1:0] h_cnt;
    logic [VWIDTH-1:0] v_cnt;
    logic              frame_first;
    logic              frame_end;
    logic              line_active;
    logic              vsync_line;

    logic [HWIDTH-1:0] pix_idx;
    logic [2:0]        bar;
    logic [DW-1:0]     pix;

    cam_timing_cnt #(
        .HEND   (HEND),
        .HON    (HON),
        .VEND   (VEND),
        .VPEND  (VPEND),
        .VBEND  (VBEND),
        .HWIDTH (HWIDTH),
        .VWIDTH (VWIDTH)
    ) u_tcnt (
        .PCLK        (PCLK),
        .RST_N       (RST_N),
        .run         (state == ST_RUN),
        .h_cnt       (h_cnt),
        .v_cnt       (v_cnt),
        .frame_first (frame_first),
        .frame_end   (frame_end),
        .line_active (line_active),
        .vsync_line  (vsync_line)
    );

    assign pix_idx = h_cnt - HWIDTH'(HON + 1);
    assign bar     = 3'(pix_idx >> BAR_SHIFT);

    always_comb begin
        pix = '0;
        unique case (mode_q)
            MODE_LEGACY: pix = h_cnt[3] ? DW'(v_cnt) : DW'(h_cnt >> 4);
            MODE_BARS:   pix = {bar, {(DW-3){1'b0}}};
            MODE_RAMP:   pix = DW'(pix_idx) + DW'(frame_cnt);
            MODE_FIXED:  pix = fixed_q;
        endcase
    end

    always_ff @(posedge PCLK) begin
        if (!RST_N) begin
            state      <= ST_IDLE;
            mode_q     <= MODE_LEGACY;
            fixed_q    <= '0;
            frame_cnt  <= '0;
            CamHsync   <= 1'b0;
            CamVsync   <= 1'b1;
            CamData    <= '0;
            FrameStart <= 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    CamHsync   <= 1'b0;
                    CamVsync   <= 1'b1;
                    CamData    <= '0;
                    FrameStart <= 1'b0;
                    if (EN)
                        state <= ST_RUN;
                end
                ST_RUN: begin
                    CamHsync   <= line_active;
                    CamVsync   <= vsync_line;
                    CamData    <= line_active ? pix : '0;
                    FrameStart <= frame_first;
                    // line 0 is always blank, so latching here
                    // cannot disturb a visible pixel
                    if (frame_first) begin
                        mode_q  <= cam_mode_e'(MODE);
                        fixed_q <= FIXED_VAL;
                    end
                    if (frame_end) begin
                        frame_cnt <= frame_cnt + 16'd1;
                        if (!EN)
                            state <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    assign FrameCnt = frame_cnt;

endmodule

// File: tb/tb_cam_pattern_gen.sv
// Scoreboard bench for cam_pattern_gen on a reduced raster.
// A frame-position reference model feeds a queue; a monitor compares.
module tb_cam_pattern_gen;

    localparam int HEND  = 47;
    localparam int HON   = 7;
    localparam int VEND  = 11;
    localparam int VPEND = 1;
    localparam int VBEND = 3;
    localparam int BSH   = 2;
    localparam int L     = HEND + 1;
    localparam int N     = L * (VEND + 1);

    logic        PCLK;
    logic        RST_N;
    logic        EN;
    logic [1:0]  MODE;
    logic [7:0]  FIXED_VAL;
    logic        CamHsync;
    logic        CamVsync;
    logic [7:0]  CamData;
    logic        FrameStart;
    logic [15:0] FrameCnt;

    typedef struct {
        logic        hs;
        logic        vs;
        logic [7:0]  data;
        logic        fs;
        logic [15:0] fcnt;
    } exp_t;

    exp_t q[$];
    int   n_chk;
    int   n_fail;
    int   cyc;

    bit         m_run;
    int         m_pos;
    int         m_fcnt;
    int         m_mode;
    logic [7:0] m_fix;

    cam_pattern_gen #(
        .HEND      (HEND),
        .HON       (HON),
        .VEND      (VEND),
        .VPEND     (VPEND),
        .VBEND     (VBEND),
        .HWIDTH    (11),
        .VWIDTH    (9),
        .DW        (8),
        .BAR_SHIFT (BSH)
    ) dut (
        .PCLK       (PCLK),
        .RST_N      (RST_N),
        .EN         (EN),
        .MODE       (MODE),
        .FIXED_VAL  (FIXED_VAL),
        .CamHsync   (CamHsync),
        .CamVsync   (CamVsync),
        .CamData    (CamData),
        .FrameStart (FrameStart),
        .FrameCnt   (FrameCnt)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    function automatic logic [7:0] pixel(int mode, int h, int v,
                                         int fc, logic [7:0] fix);
        int p;
        p = h - (HON + 1);
        case (mode)
            0: begin
                if ((h / 8) % 2 == 0)
                    return 8'((h / 16) % 256);
                return 8'(v % 256);
            end
            1: return 8'(((p / (1 << BSH)) % 8) * 32);
            2: return 8'((p + fc) % 256);
            default: return fix;
        endcase
    endfunction

    // Reference model: frame position as a single linear index
    always @(posedge PCLK) begin
        exp_t e;
        int h;
        int v;
        e.hs = 1'b0;
        e.vs = 1'b1;
        e.data = 8'h00;
        e.fs = 1'b0;
        if (!RST_N) begin
            m_run  = 1'b0;
            m_pos  = 0;
            m_fcnt = 0;
            m_mode = 0;
            m_fix  = 8'h00;
        end else if (!m_run) begin
            if (EN)
                m_run = 1'b1;
        end else begin
            h = m_pos % L;
            v = m_pos / L;
            if (m_pos == 0) begin
                m_mode = int'(MODE);
                m_fix  = FIXED_VAL;
            end
            e.fs = (m_pos == 0);
            e.vs = (v <= VPEND);
            e.hs = (h > HON) && (v > VBEND);
            if (e.hs)
                e.data = pixel(m_mode, h, v, m_fcnt, m_fix);
            if (m_pos == N - 1) begin
                m_fcnt = (m_fcnt + 1) % 65536;
                if (!EN)
                    m_run = 1'b0;
            end
            m_pos = (m_pos + 1) % N;
        end
        e.fcnt = 16'(m_fcnt);
        q.push_back(e);
    end

    always @(negedge PCLK) begin
        exp_t e;
        cyc = cyc + 1;
        if (q.size() > 0) begin
            e = q.pop_front();
            n_chk = n_chk + 1;
            if (CamHsync !== e.hs || CamVsync !== e.vs ||
                CamData !== e.data || FrameStart !== e.fs ||
                FrameCnt !== e.fcnt) begin
                n_fail = n_fail + 1;
                $display("FAIL outputs cyc %0d: got hs=%b vs=%b d=%h fs=%b fc=%0d exp hs=%b vs=%b d=%h fs=%b fc=%0d",
                         cyc, CamHsync, CamVsync, CamData, FrameStart,
                         FrameCnt, e.hs, e.vs, e.data, e.fs, e.fcnt);
            end
        end
    end

    task automatic step(int n);
        repeat (n) @(negedge PCLK);
    endtask

    task automatic pulse_reset();
        RST_N = 1'b0;
        step(1);
        RST_N = 1'b1;
    endtask

    initial begin
        n_chk     = 0;
        n_fail    = 0;
        cyc       = 0;
        RST_N     = 1'b0;
        EN        = 1'b0;
        MODE      = 2'd0;
        FIXED_VAL = 8'h00;
        step(3);
        RST_N = 1'b1;
        step(4);
        // legacy mode, two frames
        EN = 1'b1;
        step(2 * N + 10);
        // bars, switched mid-frame
        MODE = 2'd1;
        step(2 * N);
        // ramp across several frames
        MODE = 2'd2;
        step(3 * N);
        // legacy then fixed 0xA5 mid-frame
        MODE = 2'd0;
        step(N);
        MODE      = 2'd3;
        FIXED_VAL = 8'hA5;
        step(2 * N);
        // drop EN mid-frame, frame must complete, then idle
        step(6 * L);
        EN = 1'b0;
        step(N + 40);
        FIXED_VAL = 8'h3C;
        EN = 1'b1;
        step(N / 2);
        // reset for one cycle mid-frame with EN held high
        pulse_reset();
        step(N + 30);
        // randomized phase
        for (int i = 0; i < 30; i++) begin
            EN        = ($urandom_range(0, 4) != 0);
            MODE      = 2'($urandom_range(0, 3));
            FIXED_VAL = 8'($urandom);
            if ($urandom_range(0, 7) == 0)
                pulse_reset();
            step($urandom_range(20, 900));
        end
        step(2);
        #1;
        n_chk = n_chk + 1;
        if (q.size() != 0) begin
            n_fail = n_fail + 1;
            $display("FAIL queue drain: got %0d entries left, need 0",
                     q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
